// File: rtl/shift_pkg.sv
// Shared mode encodings for the universal shift register and its bench.
package shift_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_HOLD = 2'b00;
    localparam logic [MODE_W-1:0] MODE_SHL  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_SHR  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_bit_slice.sv
// One storage bit of the universal shift register: 4:1 mux in front of a flop.
module usr_bit_slice
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] mode,
    input  logic              shl_in,
    input  logic              shr_in,
    input  logic              d,
    output logic              q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case (mode)
                MODE_SHL:  q <= shl_in;
                MODE_SHR:  q <= shr_in;
                MODE_LOAD: q <= d;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with hold/shift-left/shift-right/load, saturating shift counter
// and Done/Empty status. Optional macro ROTATE_EN adds a Rotate input for circular shifts.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enable,
    input  logic [MODE_W-1:0] Mode,
    input  logic              SerInL,
    input  logic              SerInR,
    input  logic [WIDTH-1:0]  D,
`ifdef ROTATE_EN
    input  logic              Rotate,
`endif
    output logic [WIDTH-1:0]  Q,
    output logic              SerOutL,
    output logic              SerOutR,
    output logic [CNT_W-1:0]  ShiftCnt,
    output logic              Empty,
    output logic              Done
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [MODE_W-1:0] eff_mode;
    logic              fill_l;
    logic              fill_r;
    logic [WIDTH-1:0]  shl_src;
    logic [WIDTH-1:0]  shr_src;
    logic              is_shift;

    // Enable low collapses every mode to hold so the slices and counter agree.
    assign eff_mode = Enable ? Mode : MODE_HOLD;
    assign is_shift = (eff_mode == MODE_SHL) || (eff_mode == MODE_SHR);

`ifdef ROTATE_EN
    assign fill_l = Rotate ? Q[WIDTH-1] : SerInL;
    assign fill_r = Rotate ? Q[0]       : SerInR;
`else
    assign fill_l = SerInL;
    assign fill_r = SerInR;
`endif

    assign shl_src = {Q[WIDTH-2:0], fill_l};
    assign shr_src = {fill_r, Q[WIDTH-1:1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        usr_bit_slice u_slice (
            .clk    (Clock),
            .rst    (Reset),
            .mode   (eff_mode),
            .shl_in (shl_src[i]),
            .shr_in (shr_src[i]),
            .d      (D[i]),
            .q      (Q[i])
        );
    end

    // Shift counter saturates at WIDTH; Done marks the shift that reaches it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ShiftCnt <= CNT_FULL;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (eff_mode == MODE_LOAD) begin
                ShiftCnt <= '0;
            end else if (is_shift) begin
                if (ShiftCnt != CNT_FULL) begin
                    ShiftCnt <= ShiftCnt + CNT_W'(1);
                end
                Done <= (ShiftCnt == CNT_LAST);
            end
        end
    end

    assign SerOutL = Q[WIDTH-1];
    assign SerOutR = Q[0];
    assign Empty   = (ShiftCnt == CNT_FULL);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8); define ROTATE_EN to exercise rotation.
module tb_univ_shift_reg;
    import shift_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W + 1);

    typedef struct {
        int          id;
        logic [W-1:0] q;
        logic [CW-1:0] cnt;
        logic        done;
        logic        empty;
        logic        sol;
        logic        sor;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [1:0]    mode = MODE_HOLD;
    logic          ser_in_l = 1'b0;
    logic          ser_in_r = 1'b0;
    logic [W-1:0]  d = '0;
`ifdef ROTATE_EN
    logic          rotate = 1'b0;
`endif
    logic [W-1:0]  q;
    logic          ser_out_l;
    logic          ser_out_r;
    logic [CW-1:0] shift_cnt;
    logic          empty;
    logic          done;

    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            step_id = 0;

    // Reference state
    logic [W-1:0]  m_q = '0;
    int            m_cnt = W;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W)) dut (
        .Clock    (clk),
        .Reset    (reset),
        .Enable   (enable),
        .Mode     (mode),
        .SerInL   (ser_in_l),
        .SerInR   (ser_in_r),
        .D        (d),
`ifdef ROTATE_EN
        .Rotate   (rotate),
`endif
        .Q        (q),
        .SerOutL  (ser_out_l),
        .SerOutR  (ser_out_r),
        .ShiftCnt (shift_cnt),
        .Empty    (empty),
        .Done     (done)
    );

    // Drive one cycle of stimulus and push the state expected after the next edge.
    task automatic step(input logic rst, input logic en, input logic [1:0] md,
                        input logic sl, input logic sr, input logic [W-1:0] dv,
                        input logic rot);
        exp_t e;
        logic m_done;
        @(negedge clk);
        reset = rst; enable = en; mode = md; ser_in_l = sl; ser_in_r = sr; d = dv;
`ifdef ROTATE_EN
        rotate = rot;
`endif
        m_done = 1'b0;
        if (rst) begin
            m_q = '0; m_cnt = W;
        end else if (en && md == MODE_LOAD) begin
            m_q = dv; m_cnt = 0;
        end else if (en && (md == MODE_SHL || md == MODE_SHR)) begin
            m_done = (m_cnt == W - 1);
            if (m_cnt < W) m_cnt = m_cnt + 1;
            if (md == MODE_SHL) m_q = {m_q[W-2:0], rot ? m_q[W-1] : sl};
            else                m_q = {rot ? m_q[0] : sr, m_q[W-1:1]};
        end
        e.id = step_id; e.q = m_q; e.cnt = CW'(m_cnt); e.done = m_done;
        e.empty = (m_cnt == W); e.sol = m_q[W-1]; e.sor = m_q[0];
        exp_q.push_back(e);
        step_id++;
    endtask

    task automatic load(input logic [W-1:0] dv);
        step(1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, dv, 1'b0);
    endtask

    task automatic shift(input logic [1:0] md, input logic sin);
        step(1'b0, 1'b1, md, sin, sin, '0, 1'b0);
    endtask

    // Monitor: compare the DUT against the oldest pending expectation after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (q !== e.q || shift_cnt !== e.cnt || done !== e.done ||
                    empty !== e.empty || ser_out_l !== e.sol || ser_out_r !== e.sor) begin
                    n_fail++;
                    $display("FAIL step%0d: got q=%h cnt=%0d done=%b empty=%b sol=%b sor=%b, want q=%h cnt=%0d done=%b empty=%b sol=%b sor=%b",
                             e.id, q, shift_cnt, done, empty, ser_out_l, ser_out_r,
                             e.q, e.cnt, e.done, e.empty, e.sol, e.sor);
                end
            end
        end
    end

    initial begin
        // 1: reset
        step(1'b1, 1'b0, MODE_HOLD, 1'b0, 1'b0, '0, 1'b0);
        // 2: load A5, eight left shifts with zero fill
        load(8'hA5);
        for (int i = 0; i < 8; i++) shift(MODE_SHL, 1'b0);
        // 3: load 81, shift right with one fill, then enable low and explicit hold
        load(8'h81);
        shift(MODE_SHR, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, MODE_SHL, 1'b1, 1'b1, 8'hFF, 1'b0);
        step(1'b0, 1'b1, MODE_HOLD, 1'b1, 1'b1, 8'hFF, 1'b0);
        // 4: load 3C, seven mixed shifts, load FF on the cycle that would have completed
        load(8'h3C);
        for (int i = 0; i < 7; i++) shift((i % 2 == 0) ? MODE_SHL : MODE_SHR, 1'(i % 3 == 0));
        load(8'hFF);
        shift(MODE_SHR, 1'b0);
        // 5: load 0F, four left shifts, reset mid-sequence, then saturating shifts
        load(8'h0F);
        for (int i = 0; i < 4; i++) shift(MODE_SHL, 1'b1);
        step(1'b1, 1'b1, MODE_SHL, 1'b1, 1'b1, '0, 1'b0);
        for (int i = 0; i < 9; i++) shift(MODE_SHL, 1'b1);
        // Shift fill while already empty, to the right
        for (int i = 0; i < 3; i++) shift(MODE_SHR, 1'b0);
        // Reset dominates a load request
        step(1'b1, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h5A, 1'b0);
`ifdef ROTATE_EN
        // 6: rotation left eight times returns the original pattern
        load(8'h81);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, MODE_SHL, 1'b0, 1'b0, '0, 1'b1);
        load(8'h81);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, MODE_SHR, 1'b0, 1'b0, '0, 1'b1);
`endif
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: pending=%0d, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
